// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and constants for the two-master bus arbiter
package bus_arbiter_pkg;

  localparam int SEL_W = 2;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M1   = 2'b01;
  localparam logic [1:0] GNT_M2   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GNT_M1 = 2'b01,
    ST_GNT_M2 = 2'b10
  } arb_state_e;

  // Owner code for a state; anything unrecognised reads as no owner.
  function automatic logic [1:0] grant_code(input arb_state_e st);
    case (st)
      ST_GNT_M1: grant_code = GNT_M1;
      ST_GNT_M2: grant_code = GNT_M2;
      default:   grant_code = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant bundle between the two masters and the arbiter
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic             m1_request;
  logic             m2_request;
  logic [SEL_W-1:0] m1_slave_sel;
  logic [SEL_W-1:0] m2_slave_sel;
  logic             m1_grant;
  logic             m2_grant;
  logic             arbiter_busy;
  logic [1:0]       bus_grant;
  logic [SEL_W-1:0] slave_sel;

  modport master (
    output m1_request, m2_request, m1_slave_sel, m2_slave_sel,
    input  m1_grant, m2_grant, arbiter_busy, bus_grant, slave_sel
  );

  modport slave (
    input  m1_request, m2_request, m1_slave_sel, m2_slave_sel,
    output m1_grant, m2_grant, arbiter_busy, bus_grant, slave_sel
  );

endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - fixed-priority, non-preemptive two-master arbiter with latched slave select
module bus_arbiter
  import bus_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_nxt;
  logic             m1_grant_q;
  logic             m2_grant_q;
  logic             busy_q;
  logic [1:0]       bus_grant_q;

  // The select is captured only on entry to a grant; while the owner keeps
  // the bus the latched value is recirculated.
  always_comb begin
    state_nxt = ST_IDLE;
    sel_nxt   = '0;
    case (state)
      ST_IDLE: begin
        if (bus.m1_request) begin
          state_nxt = ST_GNT_M1;
          sel_nxt   = bus.m1_slave_sel;
        end else if (bus.m2_request) begin
          state_nxt = ST_GNT_M2;
          sel_nxt   = bus.m2_slave_sel;
        end
      end
      ST_GNT_M1: begin
        if (bus.m1_request) begin
          state_nxt = ST_GNT_M1;
          sel_nxt   = sel_q;
        end else if (bus.m2_request) begin
          state_nxt = ST_GNT_M2;
          sel_nxt   = bus.m2_slave_sel;
        end
      end
      ST_GNT_M2: begin
        if (bus.m2_request) begin
          state_nxt = ST_GNT_M2;
          sel_nxt   = sel_q;
        end else if (bus.m1_request) begin
          state_nxt = ST_GNT_M1;
          sel_nxt   = bus.m1_slave_sel;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        sel_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      sel_q       <= '0;
      m1_grant_q  <= 1'b0;
      m2_grant_q  <= 1'b0;
      busy_q      <= 1'b0;
      bus_grant_q <= GNT_NONE;
    end else begin
      state       <= state_nxt;
      sel_q       <= sel_nxt;
      m1_grant_q  <= (state_nxt == ST_GNT_M1);
      m2_grant_q  <= (state_nxt == ST_GNT_M2);
      busy_q      <= (state_nxt == ST_GNT_M1) || (state_nxt == ST_GNT_M2);
      bus_grant_q <= grant_code(state_nxt);
    end
  end

  assign bus.m1_grant     = m1_grant_q;
  assign bus.m2_grant     = m2_grant_q;
  assign bus.arbiter_busy = busy_q;
  assign bus.bus_grant    = bus_grant_q;
  assign bus.slave_sel    = sel_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter
module tb_bus_arbiter;

  logic clk;
  logic rst;

  bus_arbiter_if bus ();

  bus_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector layout: {m1_grant, m2_grant, arbiter_busy, bus_grant[1:0], slave_sel[1:0]}
  logic [6:0] sb[$];
  logic [6:0] exp_v;
  int         n_cmp = 0;
  int         n_mis = 0;

  function automatic logic [6:0] observed();
    return {bus.m1_grant, bus.m2_grant, bus.arbiter_busy, bus.bus_grant, bus.slave_sel};
  endfunction

  function automatic logic [6:0] exp_idle();
    return 7'b000_00_00;
  endfunction

  function automatic logic [6:0] exp_m1(input logic [1:0] sel);
    return {3'b101, 2'b01, sel};
  endfunction

  function automatic logic [6:0] exp_m2(input logic [1:0] sel);
    return {3'b011, 2'b10, sel};
  endfunction

  // Drives one cycle of requests, records what the arbiter must show after the
  // edge, and leaves time 1 unit past that edge.
  task automatic drive_cycle(input logic r1, input logic r2,
                             input logic [1:0] s1, input logic [1:0] s2,
                             input logic [6:0] exp);
    bus.m1_request   = r1;
    bus.m2_request   = r2;
    bus.m1_slave_sel = s1;
    bus.m2_slave_sel = s2;
    sb.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst              = 1'b0;
    bus.m1_request   = 1'b1;
    bus.m2_request   = 1'b1;
    bus.m1_slave_sel = 2'b10;
    bus.m2_slave_sel = 2'b11;
    sb.push_back(exp_idle());
    #2;
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL reset_immediate: got %b expected %b", observed(), exp_v);
    end
    for (int i = 0; i < 2; i++) begin
      sb.push_back(exp_idle());
      @(posedge clk); #1;
      exp_v = sb.pop_front(); n_cmp++;
      if (observed() !== exp_v) begin
        n_mis++; $display("FAIL reset_held_%0d: got %b expected %b", i, observed(), exp_v);
      end
    end
    rst = 1'b1;
    drive_cycle(1'b1, 1'b1, 2'b10, 2'b11, exp_m1(2'b10));
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL reset_release_m1: got %b expected %b", observed(), exp_v);
    end
    drive_cycle(1'b0, 1'b0, 2'b00, 2'b00, exp_idle());
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL reset_to_idle: got %b expected %b", observed(), exp_v);
    end
  endtask

  task automatic test_m1_alone();
    drive_cycle(1'b1, 1'b0, 2'b10, 2'b00, exp_m1(2'b10));
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL m1_alone_grant: got %b expected %b", observed(), exp_v);
    end
    drive_cycle(1'b1, 1'b0, 2'b10, 2'b00, exp_m1(2'b10));
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL m1_alone_hold: got %b expected %b", observed(), exp_v);
    end
  endtask

  task automatic test_no_preempt_m1();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b1, 2'b01, 2'b10, exp_m1(2'b10));
      exp_v = sb.pop_front(); n_cmp++;
      if (observed() !== exp_v) begin
        n_mis++; $display("FAIL m1_no_preempt_%0d: got %b expected %b", i, observed(), exp_v);
      end
    end
  endtask

  task automatic test_handover_to_m2();
    drive_cycle(1'b0, 1'b1, 2'b01, 2'b11, exp_m2(2'b11));
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL handover_m2: got %b expected %b", observed(), exp_v);
    end
    drive_cycle(1'b0, 1'b1, 2'b01, 2'b00, exp_m2(2'b11));
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL m2_sel_held: got %b expected %b", observed(), exp_v);
    end
  endtask

  task automatic test_m2_hold();
    drive_cycle(1'b1, 1'b1, 2'b10, 2'b00, exp_m2(2'b11));
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL m2_no_preempt: got %b expected %b", observed(), exp_v);
    end
    drive_cycle(1'b1, 1'b0, 2'b10, 2'b01, exp_m1(2'b10));
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL handover_m1: got %b expected %b", observed(), exp_v);
    end
    drive_cycle(1'b0, 1'b0, 2'b11, 2'b11, exp_idle());
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL m1_drop_idle: got %b expected %b", observed(), exp_v);
    end
  endtask

  task automatic test_idle_m2_then_release();
    drive_cycle(1'b0, 1'b1, 2'b11, 2'b01, exp_m2(2'b01));
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL idle_m2_grant: got %b expected %b", observed(), exp_v);
    end
    drive_cycle(1'b0, 1'b0, 2'b11, 2'b01, exp_idle());
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL m2_drop_idle: got %b expected %b", observed(), exp_v);
    end
  endtask

  task automatic test_back_to_back();
    drive_cycle(1'b1, 1'b1, 2'b00, 2'b11, exp_m1(2'b00));
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL b2b_simul_m1: got %b expected %b", observed(), exp_v);
    end
    drive_cycle(1'b0, 1'b1, 2'b00, 2'b10, exp_m2(2'b10));
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL b2b_to_m2: got %b expected %b", observed(), exp_v);
    end
    drive_cycle(1'b1, 1'b0, 2'b01, 2'b10, exp_m1(2'b01));
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL b2b_to_m1: got %b expected %b", observed(), exp_v);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, 1'b0, 2'b01, 2'b00, exp_m1(2'b01));
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL async_pre_grant: got %b expected %b", observed(), exp_v);
    end
    #2;
    rst = 1'b0;
    sb.push_back(exp_idle());
    #1;
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL async_midcycle: got %b expected %b", observed(), exp_v);
    end
    sb.push_back(exp_idle());
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL async_held_edge: got %b expected %b", observed(), exp_v);
    end
    rst = 1'b1;
    drive_cycle(1'b0, 1'b1, 2'b01, 2'b01, exp_m2(2'b01));
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL async_restart_m2: got %b expected %b", observed(), exp_v);
    end
    drive_cycle(1'b0, 1'b0, 2'b00, 2'b00, exp_idle());
    exp_v = sb.pop_front(); n_cmp++;
    if (observed() !== exp_v) begin
      n_mis++; $display("FAIL async_final_idle: got %b expected %b", observed(), exp_v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_m1_alone();
    test_no_preempt_m1();
    test_handover_to_m2();
    test_m2_hold();
    test_idle_m2_then_release();
    test_back_to_back();
    test_async_reset();
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
